// File: rtl/matmul_host_sequencer.sv
// matmul_host_sequencer: takes 8 operand bytes, loads a 2x2 matmul engine,
// runs it and streams the four 17-bit products out over valid/ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   in_valid/in_data/in_ready
//                         operand byte stream, A00..A11 then B00..B11
//   mm_sel_in/mm_input_val/mm_execute/mm_sel_out/mm_result
//                         engine load, execute and result-select interface
//   out_valid/out_data/out_index/out_ready
//                         result stream, index is {i,j}
//   busy                  high whenever not waiting for operands
//   done                  one-cycle pulse on the 4th result handshake
module matmul_host_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [2:0]  mm_sel_in,
  output logic [7:0]  mm_input_val,
  output logic        mm_execute,
  output logic [1:0]  mm_sel_out,
  input  logic [16:0] mm_result,
  output logic        out_valid,
  output logic [16:0] out_data,
  output logic [1:0]  out_index,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FLUSH,
    S_EXEC,
    S_CAPTURE,
    S_PRESENT,
    S_SELECT
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      r_state;
  logic [2:0]  r_count;
  logic [1:0]  r_idx;
  logic [3:0]  r_settle;
  logic [2:0]  r_sel_in;
  logic [7:0]  r_val;
  logic        r_exec;
  logic [1:0]  r_sel_out;
  logic        r_out_valid;
  logic [16:0] r_out_data;
  logic [1:0]  r_out_index;
  logic        r_done;

  logic w_in_fire;
  logic w_out_fire;
  logic w_last_res;

  assign in_ready   = (r_state == S_LOAD);
  assign busy       = (r_state != S_LOAD);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_last_res = (r_idx == 2'd3);

  // Select and value always move together so the engine never
  // writes a new value into a stale element slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_LOAD;
      r_count     <= '0;
      r_idx       <= '0;
      r_settle    <= '0;
      r_sel_in    <= '0;
      r_val       <= '0;
      r_exec      <= 1'b0;
      r_sel_out   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_sel_in <= r_count;
            r_val    <= in_data;
            r_count  <= r_count + 3'd1;
            if (r_count == 3'd7)
              r_state <= S_FLUSH;
          end
        end
        // Execute stays low one more edge so the 8th byte lands.
        S_FLUSH: begin
          r_exec    <= 1'b1;
          r_sel_out <= '0;
          r_settle  <= SETTLE_INIT;
          r_state   <= S_EXEC;
        end
        S_EXEC: begin
          if (r_settle == 4'd0)
            r_state <= S_CAPTURE;
          else
            r_settle <= r_settle - 4'd1;
        end
        S_CAPTURE: begin
          r_out_data  <= mm_result;
          r_out_index <= r_idx;
          r_out_valid <= 1'b1;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            if (w_last_res) begin
              r_done    <= 1'b1;
              r_exec    <= 1'b0;
              r_count   <= '0;
              r_idx     <= '0;
              r_sel_out <= '0;
              r_state   <= S_LOAD;
            end else begin
              r_idx     <= r_idx + 2'd1;
              r_sel_out <= r_idx + 2'd1;
              r_state   <= S_SELECT;
            end
          end
        end
        // One idle cycle for the engine's result mux to follow sel_out.
        S_SELECT: begin
          r_state <= S_CAPTURE;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign mm_sel_in    = r_sel_in;
  assign mm_input_val = r_val;
  assign mm_execute   = r_exec;
  assign mm_sel_out   = r_sel_out;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_index    = r_out_index;
  assign done         = r_done;

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// tb_matmul_host_sequencer: directed checks of the matmul sequencer
// against a small 2x2 engine model, at SETTLE_CYCLES of 1, 0 and 5.
module tb_matmul_host_sequencer;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_valid_x;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_rdy [N];
  logic        bsy [N];
  logic        dn [N];
  logic        ov [N];
  logic        exe [N];
  logic        ordy [N];
  logic [2:0]  sel_in [N];
  logic [7:0]  mval [N];
  logic [1:0]  sel_out [N];
  logic [1:0]  oidx [N];
  logic [16:0] res [N];
  logic [16:0] odata [N];

  assign ordy[0] = out_ready;
  assign ordy[1] = 1'b1;
  assign ordy[2] = 1'b1;

  matmul_host_sequencer #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_rdy[0]),
    .mm_sel_in(sel_in[0]), .mm_input_val(mval[0]),
    .mm_execute(exe[0]), .mm_sel_out(sel_out[0]),
    .mm_result(res[0]),
    .out_valid(ov[0]), .out_data(odata[0]), .out_index(oidx[0]),
    .out_ready(ordy[0]), .busy(bsy[0]), .done(dn[0])
  );

  matmul_host_sequencer #(.SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid_x), .in_data(in_data), .in_ready(in_rdy[1]),
    .mm_sel_in(sel_in[1]), .mm_input_val(mval[1]),
    .mm_execute(exe[1]), .mm_sel_out(sel_out[1]),
    .mm_result(res[1]),
    .out_valid(ov[1]), .out_data(odata[1]), .out_index(oidx[1]),
    .out_ready(ordy[1]), .busy(bsy[1]), .done(dn[1])
  );

  matmul_host_sequencer #(.SETTLE_CYCLES(5)) u_s5 (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid_x), .in_data(in_data), .in_ready(in_rdy[2]),
    .mm_sel_in(sel_in[2]), .mm_input_val(mval[2]),
    .mm_execute(exe[2]), .mm_sel_out(sel_out[2]),
    .mm_result(res[2]),
    .out_valid(ov[2]), .out_data(odata[2]), .out_index(oidx[2]),
    .out_ready(ordy[2]), .busy(bsy[2]), .done(dn[2])
  );

  // Engine model: elements 0..3 are A00..A11, 4..7 are B00..B11.
  logic [7:0] eng [N][8];

  always @(posedge clk)
    for (int k = 0; k < N; k++)
      if (!exe[k]) eng[k][sel_in[k]] <= mval[k];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      res[k] = 17'd0;
      if (exe[k])
        res[k] =
          17'(eng[k][{1'b0, sel_out[k][1], 1'b0}]) *
          17'(eng[k][{2'b10, sel_out[k][0]}]) +
          17'(eng[k][{1'b0, sel_out[k][1], 1'b1}]) *
          17'(eng[k][{2'b11, sel_out[k][0]}]);
    end
  end

  int cyc = 0;
  int t_last = 0;
  int lat [N];
  int dcnt [N];
  logic [20:0] rq [$];

  initial
    for (int k = 0; k < N; k++) begin
      lat[k]  = -1;
      dcnt[k] = 0;
    end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (ov[k] && ordy[k])
        rq.push_back({2'(k), oidx[k], odata[k]});
      if (dn[k]) dcnt[k] = dcnt[k] + 1;
    end
  end

  always @(negedge clk)
    for (int k = 0; k < N; k++)
      if (ov[k] && lat[k] < 0) lat[k] = cyc - t_last;

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while ((bsy[0] | bsy[1] | bsy[2]) && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_idle"}, 32'(g < 400), 1);
  endtask

  task automatic wait_ov(input string tag);
    int g;
    g = 0;
    while (!ov[0] && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_ov"}, 32'(g < 100), 1);
  endtask

  task automatic send(input logic [63:0] v);
    wait_idle("send");
    for (int k = 0; k < N; k++) lat[k] = -1;
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_valid_x = 1'b1;
      in_data    = v[63-8*i -: 8];
      @(negedge clk);
    end
    in_valid   = 1'b0;
    in_valid_x = 1'b0;
    t_last     = cyc;
  endtask

  task automatic expect4(input string tag, input int k,
                         input logic [16:0] c0, input logic [16:0] c1,
                         input logic [16:0] c2, input logic [16:0] c3);
    logic [16:0] e [4];
    int n;
    e = '{c0, c1, c2, c3};
    n = 0;
    foreach (rq[q])
      if (rq[q][20:19] == 2'(k)) begin
        if (n < 4) begin
          chk({tag, "_idx"}, 32'(rq[q][18:17]), n);
          chk({tag, "_val"}, 32'(rq[q][16:0]), 32'(e[n]));
        end
        n++;
      end
    chk({tag, "_cnt"}, n, 4);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"},  32'(in_rdy[0]), 1);
    chk({tag, "_busy"}, 32'(bsy[0]), 0);
    chk({tag, "_ov"},   32'(ov[0]), 0);
    chk({tag, "_exe"},  32'(exe[0]), 0);
    chk({tag, "_seli"}, 32'(sel_in[0]), 0);
    chk({tag, "_val"},  32'(mval[0]), 0);
    chk({tag, "_selo"}, 32'(sel_out[0]), 0);
    chk({tag, "_od"},   32'(odata[0]), 0);
    chk({tag, "_oi"},   32'(oidx[0]), 0);
    chk({tag, "_done"}, 32'(dn[0]), 0);
  endtask

  localparam logic [63:0] JOB1 = 64'h0102030405060708;
  localparam logic [63:0] JOBF = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] JOB2 = 64'h0200000203040506;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not reach summary");
    $fatal(1);
  end

  initial begin
    int d0;
    int bad;
    int g;
    logic [16:0] sd;
    logic [1:0]  si;
    logic [2:0]  ssel;
    logic [7:0]  sval;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_valid_x = 1'b0;
    in_data    = 8'd0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic job, plus settle 0 and 5 latency on the side instances.
    rq.delete();
    d0 = dcnt[0];
    send(JOB1);
    @(negedge clk);
    wait_idle("j1");
    expect4("j1", 0, 17'd19, 17'd22, 17'd43, 17'd50);
    chk("j1_lat", lat[0], 4);
    chk("j1_done", dcnt[0] - d0, 1);
    expect4("s0", 1, 17'd19, 17'd22, 17'd43, 17'd50);
    chk("s0_lat", lat[1], 3);
    expect4("s5", 2, 17'd19, 17'd22, 17'd43, 17'd50);
    chk("s5_lat", lat[2], 8);

    // Full-scale operands.
    rq.delete();
    send(JOBF);
    @(negedge clk);
    wait_idle("ff");
    expect4("ff", 0, 17'd130050, 17'd130050, 17'd130050, 17'd130050);

    // Stalled consumer.
    rq.delete();
    out_ready = 1'b0;
    send(JOB1);
    for (int r = 0; r < 4; r++) begin
      wait_ov("st");
      sd = odata[0];
      si = oidx[0];
      repeat (10) @(negedge clk);
      chk("st_data", 32'(odata[0]), 32'(sd));
      chk("st_idx", 32'(oidx[0]), r);
      chk("st_ov", 32'(ov[0]), 1);
      chk("st_exe", 32'(exe[0]), 1);
      chk("st_idx0", 32'(si), r);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("st_exe_off", 32'(exe[0]), 0);
    out_ready = 1'b1;
    wait_idle("st");
    expect4("st", 0, 17'd19, 17'd22, 17'd43, 17'd50);

    // Junk input while busy, then a second job.
    rq.delete();
    send(JOB1);
    ssel = sel_in[0];
    sval = mval[0];
    chk("jk_sel", 32'(ssel), 7);
    chk("jk_val", 32'(sval), 8);
    bad = 0;
    g = 0;
    in_valid = 1'b1;
    while (bsy[0] && g < 100) begin
      in_data = 8'($urandom);
      if (in_rdy[0] !== 1'b0) bad++;
      if (sel_in[0] !== ssel || mval[0] !== sval) bad++;
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    chk("jk_ignored", bad, 0);
    chk("jk_bound", 32'(g < 100), 1);
    wait_idle("jk");
    expect4("jk", 0, 17'd19, 17'd22, 17'd43, 17'd50);
    rq.delete();
    send(JOB2);
    @(negedge clk);
    wait_idle("j2");
    expect4("j2", 0, 17'd6, 17'd8, 17'd10, 17'd12);

    // Reset during PRESENT at idx 1.
    out_ready = 1'b0;
    send(JOB1);
    wait_ov("mr0");
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_ov("mr1");
    chk("mr_idx", 32'(oidx[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("mr");
    rst_n = 1'b1;
    out_ready = 1'b1;
    rq.delete();
    send(JOB1);
    @(negedge clk);
    wait_idle("rl");
    expect4("rl", 0, 17'd19, 17'd22, 17'd43, 17'd50);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
